// File: rtl/eth_tx_buf_rd.sv
// Frame-buffer reader: fetches 32-bit words from a buffer and streams them out
// as a little-endian byte stream with valid/ready handshake, last flag and done pulse.
module eth_tx_buf_rd #(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_e;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0]  LEN_TWO  = LEN_W'(2);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         word_q, word_d;
   logic [1:0]          idx_q, idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [7:0]          data_q, data_d;

   function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Next-state logic; output registers are loaded with the byte to be shown next cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      word_d  = word_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start && !abort && (len != '0)) begin
               state_d = FETCH;
               cnt_d   = len;
               addr_d  = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
               last_d  = 1'b0;
               data_d  = 8'h00;
            end else begin
               state_d = SEND;
               word_d  = mem_data;
               addr_d  = addr_q + ADDR_ONE;
               idx_d   = 2'd0;
               valid_d = 1'b1;
               data_d  = mem_data[7:0];
               last_d  = (cnt_q == LEN_ONE);
            end
         end
         SEND: begin
            // Abort wins even over a simultaneous final-byte transfer.
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
               last_d  = 1'b0;
               data_d  = 8'h00;
            end else if (byte_ready) begin
               if (cnt_q == LEN_ONE) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = 8'h00;
               end else begin
                  cnt_d  = cnt_q - LEN_ONE;
                  last_d = (cnt_q == LEN_TWO);
                  // Word boundary: next word is already on mem_data, so no bubble.
                  if (idx_q == 2'd3) begin
                     word_d = mem_data;
                     addr_d = addr_q + ADDR_ONE;
                     idx_d  = 2'd0;
                     data_d = mem_data[7:0];
                  end else begin
                     idx_d  = idx_q + 2'd1;
                     data_d = sel_byte(word_q, idx_q + 2'd1);
                  end
               end
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 8'h00;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         word_q  <= 32'h0000_0000;
         idx_q   <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign mem_addr   = addr_q;
   assign byte_data  = data_q;
   assign byte_valid = valid_q;
   assign byte_last  = last_q;

endmodule

// File: tb/tb_eth_tx_buf_rd.sv
// Randomized self-checking bench for eth_tx_buf_rd against a byte-stream
// reference model computed directly from the buffer contents.
module tb_eth_tx_buf_rd;

   localparam int ADDR_W = 9;
   localparam int LEN_W  = 12;
   localparam int NWORDS = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic [7:0]        byte_data;
   logic              byte_valid;
   logic              byte_ready;
   logic              byte_last;

   logic [31:0] mem [NWORDS];

   int n_checks = 0;
   int n_errors = 0;

   eth_tx_buf_rd #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last)
   );

   // Buffer read data follows the registered address.
   assign mem_data = mem[mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Byte k of a frame: frames always start at word 0, word index wraps.
   function automatic logic [7:0] model_byte(input int k);
      logic [31:0] w;
      w = mem[(k / 4) % NWORDS];
      return w[8*(k%4) +: 8];
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"},  busy, 0);
      check_eq({tag, "_done"},  done, 0);
      check_eq({tag, "_valid"}, byte_valid, 0);
      check_eq({tag, "_last"},  byte_last, 0);
      check_eq({tag, "_data"},  byte_data, 0);
      check_eq({tag, "_addr"},  mem_addr, 0);
   endtask

   // Cycle-exact frame of 8 bytes with ready=1; optional second start and abort.
   task automatic run_timed(input int restart_cyc, input int abort_cyc);
      int endc;
      endc = (abort_cyc != 0) ? abort_cyc : 9;
      start = 1'b1; len = LEN_W'(8); byte_ready = 1'b1; abort = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         check_eq("t_busy",  busy,       (c >= 1 && c <= endc));
         check_eq("t_valid", byte_valid, (c >= 2 && c <= endc));
         check_eq("t_last",  byte_last,  (c == 9 && c <= endc));
         check_eq("t_done",  done,       (abort_cyc == 0 && c == 10));
         if (c >= 2 && c <= endc)
            check_eq("t_data", byte_data, 8'(8'h11 * (c - 1)));
         start = (c == restart_cyc);
         len   = (c == restart_cyc) ? LEN_W'(3) : LEN_W'(8);
         abort = (c == abort_cyc);
      end
      start = 1'b0; abort = 1'b0;
   endtask

   // Frame with random backpressure, checked byte-by-byte against the model.
   task automatic run_frame(input int flen, input int ready_pct);
      int k, dones, cyc;
      bit stalled;
      logic [7:0] pd;
      logic pl;
      k = 0; dones = 0; cyc = 0; stalled = 1'b0; pd = 8'h00; pl = 1'b0;
      start = 1'b1; len = LEN_W'(flen); abort = 1'b0;
      byte_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      start = 1'b0;
      check_eq("f_fetch_busy",  busy, 1);
      check_eq("f_fetch_addr",  mem_addr, 0);
      check_eq("f_fetch_valid", byte_valid, 0);
      while (dones == 0 && cyc < 4 * flen + 20) begin
         if (done) begin
            dones++;
         end else begin
            if (stalled) begin
               check_eq("f_stall_valid", byte_valid, 1);
               check_eq("f_stall_data",  byte_data, pd);
               check_eq("f_stall_last",  byte_last, pl);
            end
            byte_ready = ($urandom_range(99) < ready_pct);
            if (byte_valid && byte_ready) begin
               check_eq("f_data", byte_data, model_byte(k));
               check_eq("f_last", byte_last, (k == flen - 1));
               k++;
               stalled = 1'b0;
            end else if (byte_valid) begin
               stalled = 1'b1;
               pd = byte_data;
               pl = byte_last;
            end else begin
               stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      check_eq("f_done_seen", dones, 1);
      check_eq("f_count", k, flen);
      check_eq("f_idle_busy", busy, 0);
      @(negedge clk);
      check_eq("f_done_pulse", done, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0; byte_ready = 1'b0;
      for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h4433_2211;
      mem[1] = 32'h8877_6655;
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run_timed(0, 0);
      run_frame(5, 50);

      start = 1'b1; len = '0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check_eq("len0_busy",  busy, 0);
         check_eq("len0_valid", byte_valid, 0);
         check_eq("len0_done",  done, 0);
         @(negedge clk);
      end
      run_frame(1, 100);

      start = 1'b1; len = LEN_W'(4); abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_eq("idle_abort_busy", busy, 0);
      @(negedge clk);
      check_eq("idle_abort_valid", byte_valid, 0);

      run_timed(4, 5);
      run_frame(8, 70);

      start = 1'b1; len = LEN_W'(8); byte_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("post_rst_done", done, 0);
         check_eq("post_rst_busy", busy, 0);
      end
      run_frame(6, 60);

      for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
      run_frame(2048, 100);
      check_eq("wrap_addr", mem_addr, 0);

      for (int i = 0; i < 6; i++) run_frame($urandom_range(40, 1), 60);
      run_frame(2100, 85);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eth_tx_buf_rd.md
ETH_TX_BUF_RD -- requirements
Module: eth_tx_buf_rd

Interface
REQ-001 Parameter ADDR_W, default 9, word-address width of the 32-bit frame buffer read port.
REQ-002 Parameter LEN_W, default 12, width of the byte-length input.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle frame-send request.
REQ-006 len  input  LEN_W  frame length in bytes, sampled with start.
REQ-007 abort  input  1  cancel current frame.
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  one-cycle pulse on normal frame completion.
REQ-010 mem_addr  output  ADDR_W  buffer read word address.
REQ-011 mem_data  input  32  buffer read data, valid one cycle after mem_addr changes.
REQ-012 byte_data  output  8  outgoing byte.
REQ-013 byte_valid  output  1  byte_data valid.
REQ-014 byte_ready  input  1  downstream accepts byte; transfer = byte_valid & byte_ready.
REQ-015 byte_last  output  1  high with the final byte of the frame.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SEND.
REQ-017 IDLE: start=1 and len!=0 -> latch len, mem_addr<=0, busy<=1, go FETCH; start with len=0 SHALL be ignored (no busy, no done).
REQ-018 FETCH lasts exactly one cycle; at its end mem_data SHALL be captured into the word register, mem_addr<=mem_addr+1, byte index<=0, go SEND.
REQ-019 SEND: byte_valid=1; byte_data = word[8*idx +: 8] (byte 0 = bits 7:0, little-endian).
REQ-020 byte_data, byte_last SHALL remain stable while byte_valid & !byte_ready.
REQ-021 On transfer with idx<3 and not final byte: idx<=idx+1.
REQ-022 On transfer with idx=3 and not final byte: capture mem_data (word at current mem_addr) into word register, mem_addr<=mem_addr+1, idx<=0; no bubble cycle SHALL occur.
REQ-023 Only the first word SHALL incur the FETCH cycle; latency start-sampled edge to first byte_valid = 2 cycles; throughput 1 byte/cycle with byte_ready=1.
REQ-024 Remaining-byte counter SHALL decrement per transfer; byte_last=1 when counter=1.
REQ-025 Transfer of last byte: go IDLE, busy<=0, byte_valid<=0, done=1 for the following cycle.
REQ-026 mem_addr SHALL wrap modulo 2^ADDR_W; lengths above 4*2^ADDR_W reread wrapped words.
REQ-027 A partial final word SHALL emit only the required low-order bytes.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in FETCH or SEND: next cycle IDLE, busy=0, byte_valid=0, no done; abort has priority over a simultaneous last-byte transfer; abort in IDLE has no effect; start with abort in IDLE is ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and busy, done, byte_valid, byte_last, byte_data, mem_addr, word register, counters to 0, including mid-frame.
REQ-031 After rst_n release, the first start SHALL behave per REQ-017.

Verification
REQ-032 Buffer word0=0x44332211, word1=0x88776655, len=8, byte_ready=1, start at cycle 0 -> bytes 11,22,...,88 at cycles 2-9, byte_last at cycle 9 only, done at cycle 10, busy cycles 1-9.
REQ-033 Same buffer, len=5, byte_ready pseudo-random -> bytes 11,22,33,44,55 in order, byte_last only with 55, byte_data stable during every stall, done once.
REQ-034 len=0 start -> busy, byte_valid, done stay 0; then start with len=1 -> single byte 11 with byte_last, done.
REQ-035 len=8, second start at cycle 4 ignored; abort at cycle 5 -> byte_valid=0 from cycle 6, no done, next start restarts at mem_addr 0.
REQ-036 rst_n low at cycle 5 of an 8-byte frame -> all outputs 0 asynchronously, no done after release.
REQ-037 len=2048 with ADDR_W=9 -> mem_addr runs 0..511, wraps to 0 after final fetch, 2048 bytes emitted, one done.
